// File: rtl/cmd_parser_gen.sv
// ============================================================================
// cmd_parser_gen: reader-command parser with opcode decode, length and CRC5/CRC16 checks
// Revision 1.0
// ============================================================================
`default_nettype none

module cmd_parser_gen #(
   parameter int unsigned CNT_W         = 7,
   parameter int unsigned LEN_SELECT    = 61,
   parameter int unsigned LEN_READ      = 58,
   parameter logic [15:0] CRC16_RESIDUE = 16'h1D0F,
   parameter logic [4:0]  CRC5_RESIDUE  = 5'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic [12:0]      cmd_onehot,
   output logic             cmd_valid,
   output logic             pkt_done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic             unknown_cmd,
   output logic             overrun,
   output logic [CNT_W-1:0] bit_count,
   output logic             dr,
   output logic [1:0]       m,
   output logic             trext,
   output logic [3:0]       q
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_OPCODE = 3'd1;
   localparam logic [2:0] ST_BODY   = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   localparam logic [1:0] KIND_NONE  = 2'd0;
   localparam logic [1:0] KIND_CRC5  = 2'd1;
   localparam logic [1:0] KIND_CRC16 = 2'd2;

   localparam int C_QUERYREP = 0;
   localparam int C_ACK      = 1;
   localparam int C_QUERY    = 2;
   localparam int C_QUERYADJ = 3;
   localparam int C_SELECT   = 4;
   localparam int C_NACK     = 5;
   localparam int C_REQRN    = 6;
   localparam int C_READ     = 7;
   localparam int C_WRITE    = 8;
   localparam int C_TRANS    = 9;
   localparam int C_SAMPLE   = 10;
   localparam int C_READSENS = 11;
   localparam int C_BFCONST  = 12;

   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] N_2        = CNT_W'(2);
   localparam logic [CNT_W-1:0] N_4        = CNT_W'(4);
   localparam logic [CNT_W-1:0] N_8        = CNT_W'(8);
   localparam logic [CNT_W-1:0] L_QUERYREP = CNT_W'(4);
   localparam logic [CNT_W-1:0] L_ACK      = CNT_W'(18);
   localparam logic [CNT_W-1:0] L_QUERY    = CNT_W'(22);
   localparam logic [CNT_W-1:0] L_QUERYADJ = CNT_W'(9);
   localparam logic [CNT_W-1:0] L_SELECT   = CNT_W'(LEN_SELECT);
   localparam logic [CNT_W-1:0] L_NACK     = CNT_W'(8);
   localparam logic [CNT_W-1:0] L_REQRN    = CNT_W'(40);
   localparam logic [CNT_W-1:0] L_READ     = CNT_W'(LEN_READ);
   localparam logic [CNT_W-1:0] L_WRITE    = CNT_W'(66);
   localparam logic [CNT_W-1:0] L_TRANS    = CNT_W'(14);
   localparam logic [CNT_W-1:0] L_SAMPLE   = CNT_W'(11);
   localparam logic [CNT_W-1:0] L_RDSENS   = CNT_W'(52);
   localparam logic [CNT_W-1:0] L_BFCONST  = CNT_W'(52);

   // Query field positions, 0-based within the frame
   localparam logic [CNT_W-1:0] F_DR    = CNT_W'(4);
   localparam logic [CNT_W-1:0] F_M1    = CNT_W'(5);
   localparam logic [CNT_W-1:0] F_M0    = CNT_W'(6);
   localparam logic [CNT_W-1:0] F_TREXT = CNT_W'(7);
   localparam logic [CNT_W-1:0] F_Q3    = CNT_W'(13);
   localparam logic [CNT_W-1:0] F_Q2    = CNT_W'(14);
   localparam logic [CNT_W-1:0] F_Q1    = CNT_W'(15);
   localparam logic [CNT_W-1:0] F_Q0    = CNT_W'(16);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
   logic [6:0]       op_q, op_d;
   logic [12:0]      onehot_q, onehot_d;
   logic             valid_q, valid_d, unk_q, unk_d, ovr_q, ovr_d;
   logic             pkt_done_q, pkt_done_d, crc_ok_q, crc_ok_d, crc_err_q, crc_err_d;
   logic [1:0]       kind_q, kind_d;
   logic [4:0]       crc5_q, crc5_d;
   logic [15:0]      crc16_q, crc16_d;
   logic             sh_dr_q, sh_dr_d, sh_trext_q, sh_trext_d;
   logic [1:0]       sh_m_q, sh_m_d;
   logic [3:0]       sh_q_q, sh_q_d;
   logic             dr_q, dr_d, trext_q, trext_d;
   logic [1:0]       m_q, m_d;
   logic [3:0]       q_q, q_d;

   logic [7:0]       op_shift;
   logic [CNT_W-1:0] cnt_inc, dec_len;
   logic [12:0]      dec_onehot;
   logic [1:0]       dec_kind, eff_kind;
   logic             dec_known, dec_unknown, eff_query;
   logic [4:0]       crc5_n;
   logic [15:0]      crc16_n;
   logic             accept, ovr_hit, done_entry;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : p_next
      state_d = state_q;
      if (frame_start) begin
         state_d = ST_OPCODE;
      end else if (accept) begin
         case (state_q)
            ST_OPCODE: begin
               if (dec_unknown) begin
                  state_d = ST_ERROR;
               end else if (dec_known) begin
                  state_d = (cnt_inc == dec_len) ? ST_DONE : ST_BODY;
               end
            end
            ST_BODY: begin
               if (cnt_inc == len_q) state_d = ST_DONE;
            end
            default: ;
         endcase
      end
   end

   always_comb begin : p_out
      accept     = bit_valid && !frame_start && (state_q == ST_OPCODE || state_q == ST_BODY);
      ovr_hit    = bit_valid && !frame_start && (state_q == ST_DONE);
      done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);
   end

   always_comb begin : p_decode
      op_shift    = {op_q, bit_in};
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      dec_known   = 1'b0;
      dec_unknown = 1'b0;
      dec_onehot  = '0;
      dec_len     = '0;
      dec_kind    = KIND_NONE;
      if (cnt_inc == N_2) begin
         if (!op_shift[1]) begin
            dec_known = 1'b1;
            if (op_shift[0]) begin
               dec_onehot[C_ACK] = 1'b1;
               dec_len           = L_ACK;
            end else begin
               dec_onehot[C_QUERYREP] = 1'b1;
               dec_len                = L_QUERYREP;
            end
         end
      end else if (cnt_inc == N_4 && op_shift[3:2] == 2'b10) begin
         dec_known = 1'b1;
         case (op_shift[1:0])
            2'b00: begin dec_onehot[C_QUERY] = 1'b1; dec_len = L_QUERY; dec_kind = KIND_CRC5; end
            2'b01: begin dec_onehot[C_QUERYADJ] = 1'b1; dec_len = L_QUERYADJ; end
            2'b10: begin dec_onehot[C_SELECT] = 1'b1; dec_len = L_SELECT; dec_kind = KIND_CRC16; end
            default: begin dec_known = 1'b0; dec_unknown = 1'b1; end
         endcase
      end else if (cnt_inc == N_8) begin
         dec_known = 1'b1;
         case (op_shift)
            8'hC0: begin dec_onehot[C_NACK] = 1'b1; dec_len = L_NACK; end
            8'hC1: begin dec_onehot[C_REQRN] = 1'b1; dec_len = L_REQRN; dec_kind = KIND_CRC16; end
            8'hC2: begin dec_onehot[C_READ] = 1'b1; dec_len = L_READ; dec_kind = KIND_CRC16; end
            8'hC3: begin dec_onehot[C_WRITE] = 1'b1; dec_len = L_WRITE; dec_kind = KIND_CRC16; end
            8'hDA: begin dec_onehot[C_TRANS] = 1'b1; dec_len = L_TRANS; end
            8'hDF: begin dec_onehot[C_SAMPLE] = 1'b1; dec_len = L_SAMPLE; end
            8'hD8: begin dec_onehot[C_READSENS] = 1'b1; dec_len = L_RDSENS; dec_kind = KIND_CRC16; end
            8'hDE: begin dec_onehot[C_BFCONST] = 1'b1; dec_len = L_BFCONST; end
            default: begin dec_known = 1'b0; dec_unknown = 1'b1; end
         endcase
      end
      crc5_n  = {crc5_q[3:0], 1'b0} ^ ((crc5_q[4] ^ bit_in) ? 5'b01001 : 5'b00000);
      crc16_n = {crc16_q[14:0], 1'b0} ^ ((crc16_q[15] ^ bit_in) ? 16'h1021 : 16'h0000);
      // a packet can finish on its last opcode bit, so use the fresh decode there
      eff_kind  = (state_q == ST_OPCODE) ? dec_kind : kind_q;
      eff_query = (state_q == ST_OPCODE) ? dec_onehot[C_QUERY] : onehot_q[C_QUERY];
   end

   always_comb begin : p_data
      cnt_d = cnt_q;  len_d = len_q;  op_d = op_q;  onehot_d = onehot_q;
      valid_d = valid_q;  unk_d = unk_q;  ovr_d = ovr_q;  kind_d = kind_q;
      pkt_done_d = 1'b0;  crc_ok_d = crc_ok_q;  crc_err_d = crc_err_q;
      crc5_d = crc5_q;  crc16_d = crc16_q;
      sh_dr_d = sh_dr_q;  sh_m_d = sh_m_q;  sh_trext_d = sh_trext_q;  sh_q_d = sh_q_q;
      dr_d = dr_q;  m_d = m_q;  trext_d = trext_q;  q_d = q_q;
      if (frame_start) begin
         cnt_d = '0;  len_d = '0;  op_d = '0;  onehot_d = '0;  kind_d = KIND_NONE;
         valid_d = 1'b0;  unk_d = 1'b0;  ovr_d = 1'b0;
         crc_ok_d = 1'b0;  crc_err_d = 1'b0;
         crc5_d = 5'b01001;  crc16_d = 16'hFFFF;
      end else begin
         if (accept) begin
            cnt_d   = cnt_inc;
            op_d    = op_shift[6:0];
            crc5_d  = crc5_n;
            crc16_d = crc16_n;
            case (cnt_q)
               F_DR:    sh_dr_d    = bit_in;
               F_M1:    sh_m_d[1]  = bit_in;
               F_M0:    sh_m_d[0]  = bit_in;
               F_TREXT: sh_trext_d = bit_in;
               F_Q3:    sh_q_d[3]  = bit_in;
               F_Q2:    sh_q_d[2]  = bit_in;
               F_Q1:    sh_q_d[1]  = bit_in;
               F_Q0:    sh_q_d[0]  = bit_in;
               default: ;
            endcase
            if (state_q == ST_OPCODE && dec_known) begin
               onehot_d = dec_onehot;
               valid_d  = 1'b1;
               len_d    = dec_len;
               kind_d   = dec_kind;
            end
            if (state_q == ST_OPCODE && dec_unknown) unk_d = 1'b1;
         end
         if (ovr_hit) ovr_d = 1'b1;
         if (done_entry) begin
            pkt_done_d = 1'b1;
            case (eff_kind)
               KIND_CRC5: begin
                  crc_ok_d  = (crc5_d == CRC5_RESIDUE);
                  crc_err_d = (crc5_d != CRC5_RESIDUE);
               end
               KIND_CRC16: begin
                  crc_ok_d  = (crc16_d == CRC16_RESIDUE);
                  crc_err_d = (crc16_d != CRC16_RESIDUE);
               end
               default: ;
            endcase
            if (eff_query && crc_ok_d) begin
               dr_d = sh_dr_d;  m_d = sh_m_d;  trext_d = sh_trext_d;  q_d = sh_q_d;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;  len_q <= '0;  op_q <= '0;  onehot_q <= '0;
         valid_q <= 1'b0;  unk_q <= 1'b0;  ovr_q <= 1'b0;  kind_q <= KIND_NONE;
         pkt_done_q <= 1'b0;  crc_ok_q <= 1'b0;  crc_err_q <= 1'b0;
         crc5_q <= 5'b01001;  crc16_q <= 16'hFFFF;
         sh_dr_q <= 1'b0;  sh_m_q <= '0;  sh_trext_q <= 1'b0;  sh_q_q <= '0;
         dr_q <= 1'b0;  m_q <= '0;  trext_q <= 1'b0;  q_q <= '0;
      end else begin
         cnt_q <= cnt_d;  len_q <= len_d;  op_q <= op_d;  onehot_q <= onehot_d;
         valid_q <= valid_d;  unk_q <= unk_d;  ovr_q <= ovr_d;  kind_q <= kind_d;
         pkt_done_q <= pkt_done_d;  crc_ok_q <= crc_ok_d;  crc_err_q <= crc_err_d;
         crc5_q <= crc5_d;  crc16_q <= crc16_d;
         sh_dr_q <= sh_dr_d;  sh_m_q <= sh_m_d;  sh_trext_q <= sh_trext_d;  sh_q_q <= sh_q_d;
         dr_q <= dr_d;  m_q <= m_d;  trext_q <= trext_d;  q_q <= q_d;
      end
   end

   assign cmd_onehot  = onehot_q;
   assign cmd_valid   = valid_q;
   assign pkt_done    = pkt_done_q;
   assign crc_ok      = crc_ok_q;
   assign crc_err     = crc_err_q;
   assign unknown_cmd = unk_q;
   assign overrun     = ovr_q;
   assign bit_count   = cnt_q;
   assign dr          = dr_q;
   assign m           = m_q;
   assign trext       = trext_q;
   assign q           = q_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_parser_gen.sv
// ============================================================================
// tb_cmd_parser_gen: directed scoreboard bench for cmd_parser_gen
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_cmd_parser_gen;

   logic        clk = 1'b0;
   logic        rst_n, frame_start, bit_valid, bit_in;
   logic [12:0] cmd_onehot;
   logic        cmd_valid, pkt_done, crc_ok, crc_err, unknown_cmd, overrun;
   logic [6:0]  bit_count;
   logic        dr, trext;
   logic [1:0]  m;
   logic [3:0]  q;

   typedef struct {
      logic [12:0] onehot;
      logic        ok;
      logic        err;
      logic [6:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   bit          pk[$];
   int          vectors = 0;
   int          fails   = 0;
   int          done_cnt = 0;
   int          d0;
   logic [4:0]  c5;
   logic [15:0] c16;
   logic        exp_dr, exp_trext;
   logic [1:0]  exp_m;
   logic [3:0]  exp_q;

   cmd_parser_gen dut (
      .clk         (clk),
      .reset       (rst_n),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .cmd_onehot  (cmd_onehot),
      .cmd_valid   (cmd_valid),
      .pkt_done    (pkt_done),
      .crc_ok      (crc_ok),
      .crc_err     (crc_err),
      .unknown_cmd (unknown_cmd),
      .overrun     (overrun),
      .bit_count   (bit_count),
      .dr          (dr),
      .m           (m),
      .trext       (trext),
      .q           (q)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (pkt_done === 1'b1) done_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] crc5_of(input bit b[$]);
      logic [4:0] c = 5'b01001;
      foreach (b[i]) c = {c[3:0], 1'b0} ^ ((c[4] ^ b[i]) ? 5'b01001 : 5'b00000);
      return c;
   endfunction

   function automatic logic [15:0] crc16_of(input bit b[$]);
      logic [15:0] c = 16'hFFFF;
      foreach (b[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic add(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) pk.push_back(v[i]);
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic send_bit(input bit b, input int gap);
      repeat (gap) tick();
      bit_valid = 1'b1;
      bit_in    = b;
      tick();
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input int maxgap);
      for (int i = lo; i <= hi; i++) send_bit(pk[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
   endtask

   task automatic push_exp(input logic [12:0] oh, input logic ok, input logic err, input logic [6:0] cnt);
      exp_t e;
      e.onehot = oh;  e.ok = ok;  e.err = err;  e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic expect_done(input string tag);
      exp_t e;
      for (int i = 0; i < 40; i++) begin
         if (pkt_done === 1'b1) break;
         tick();
      end
      chk({tag, "_done"}, 32'(pkt_done), 32'd1);
      e = sb.pop_front();
      chk({tag, "_onehot"}, 32'(cmd_onehot), 32'(e.onehot));
      chk({tag, "_crc_ok"}, 32'(crc_ok), 32'(e.ok));
      chk({tag, "_crc_err"}, 32'(crc_err), 32'(e.err));
      chk({tag, "_count"}, 32'(bit_count), 32'(e.cnt));
      tick();
      chk({tag, "_pulse"}, 32'(pkt_done), 32'd0);
   endtask

   task automatic chk_settings(input string tag);
      chk({tag, "_dr"}, 32'(dr), 32'(exp_dr));
      chk({tag, "_m"}, 32'(m), 32'(exp_m));
      chk({tag, "_trext"}, 32'(trext), 32'(exp_trext));
      chk({tag, "_q"}, 32'(q), 32'(exp_q));
   endtask

   initial begin
      rst_n = 1'b0;  frame_start = 1'b0;  bit_valid = 1'b0;  bit_in = 1'b0;
      exp_dr = 1'b0;  exp_m = 2'd0;  exp_trext = 1'b0;  exp_q = 4'd0;
      repeat (3) tick();
      chk("rst_onehot", 32'(cmd_onehot), 32'd0);
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_flags", 32'({pkt_done, crc_ok, crc_err, unknown_cmd, overrun}), 32'd0);
      chk("rst_count", 32'(bit_count), 32'd0);
      chk_settings("rst");
      rst_n = 1'b1;
      tick();

      // Query with good CRC5 commits its link settings
      start_frame();
      pk = {};
      add(4'b1000, 4); add(1, 1); add(2'b10, 2); add(1, 1);
      add(0, 2); add(0, 2); add(0, 1); add(4'b0100, 4);
      c5 = crc5_of(pk);
      add(32'(c5), 5);
      push_exp(13'h0004, 1'b1, 1'b0, 7'd22);
      send_range(0, 3, 0);
      chk("qry_onehot_at4", 32'(cmd_onehot), 32'h4);
      chk("qry_valid_at4", 32'(cmd_valid), 32'd1);
      send_range(4, 21, 0);
      exp_dr = 1'b1;  exp_m = 2'd2;  exp_trext = 1'b1;  exp_q = 4'd4;
      expect_done("qry");
      chk_settings("qry");

      // Query with a corrupted CRC5 keeps the old settings
      start_frame();
      pk = {};
      add(4'b1000, 4); add(0, 1); add(2'b01, 2); add(0, 1);
      add(0, 2); add(0, 2); add(0, 1); add(4'b1001, 4);
      c5 = crc5_of(pk) ^ 5'b00001;
      add(32'(c5), 5);
      push_exp(13'h0004, 1'b0, 1'b1, 7'd22);
      send_range(0, 21, 0);
      expect_done("qbad");
      chk_settings("qbad");

      // ReqRN with CRC16 and gapped bits
      start_frame();
      pk = {};
      add(8'hC1, 8);
      add($urandom_range(0, 65535), 16);
      c16 = crc16_of(pk);
      add(32'(~c16), 16);
      push_exp(13'h0040, 1'b1, 1'b0, 7'd40);
      send_range(0, 39, 3);
      expect_done("reqrn");

      // Nack finishes on its last opcode bit
      start_frame();
      pk = {};
      add(8'hC0, 8);
      push_exp(13'h0020, 1'b0, 1'b0, 7'd8);
      send_range(0, 7, 1);
      expect_done("nack");

      // Unknown opcode 1011, then recovery with QueryRep
      start_frame();
      d0 = done_cnt;
      pk = {};
      add(4'b1011, 4); add(8'hFF, 8);
      send_range(0, 3, 0);
      chk("unk_flag", 32'(unknown_cmd), 32'd1);
      chk("unk_valid", 32'(cmd_valid), 32'd0);
      send_range(4, 11, 0);
      repeat (5) tick();
      chk("unk_count", 32'(bit_count), 32'd4);
      chk("unk_nodone", 32'(done_cnt), 32'(d0));
      start_frame();
      chk("unk_cleared", 32'(unknown_cmd), 32'd0);
      pk = {};
      add(4'b0001, 4);
      push_exp(13'h0001, 1'b0, 1'b0, 7'd4);
      send_range(0, 3, 0);
      expect_done("qrep");
      chk("qrep_unk", 32'(unknown_cmd), 32'd0);

      // QueryAdj followed by three overrun bits
      start_frame();
      pk = {};
      add(4'b1001, 4); add(5'b10110, 5); add(3'b101, 3);
      push_exp(13'h0008, 1'b0, 1'b0, 7'd9);
      send_range(0, 8, 0);
      expect_done("qadj");
      d0 = done_cnt;
      chk("qadj_no_ovr", 32'(overrun), 32'd0);
      send_range(9, 11, 0);
      repeat (3) tick();
      chk("qadj_overrun", 32'(overrun), 32'd1);
      chk("qadj_count", 32'(bit_count), 32'd9);
      chk("qadj_once", 32'(done_cnt), 32'(d0));

      // Write abandoned by frame_start coincident with bit 10
      start_frame();
      d0 = done_cnt;
      pk = {};
      add(8'hC3, 8); add(2'b11, 2);
      send_range(0, 9, 0);
      chk("wr_count10", 32'(bit_count), 32'd10);
      frame_start = 1'b1;  bit_valid = 1'b1;  bit_in = 1'b1;
      tick();
      frame_start = 1'b0;  bit_valid = 1'b0;  bit_in = 1'b0;
      chk("wr_abandon_count", 32'(bit_count), 32'd0);
      chk("wr_abandon_valid", 32'(cmd_valid), 32'd0);
      chk("wr_abandon_onehot", 32'(cmd_onehot), 32'd0);
      repeat (70) tick();
      chk("wr_nodone", 32'(done_cnt), 32'(d0));
      chk_settings("wr_keep");

      // asynchronous reset in the middle of a Query
      pk = {};
      add(4'b1000, 4); add(6'b101010, 6);
      send_range(0, 9, 0);
      chk("mid_count", 32'(bit_count), 32'd10);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_onehot", 32'(cmd_onehot), 32'd0);
      chk("arst_valid", 32'(cmd_valid), 32'd0);
      chk("arst_count", 32'(bit_count), 32'd0);
      exp_dr = 1'b0;  exp_m = 2'd0;  exp_trext = 1'b0;  exp_q = 4'd0;
      chk_settings("arst");
      tick();
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

`default_nettype wire
